// File: rtl/seq_shifter.sv
// seq_shifter: multi-mode sequential shifter, one bit position per clock.
// A start pulse in IDLE captures the operand, mode and saturated amount.
// The result and carry appear together with a single-cycle done pulse.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the last result
// SHIFT | one 1-bit shift of the working register per cycle
// DONE  | single cycle, done = 1, dout/carry just updated; back to IDLE

module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   amt,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_ASR = 2'b01,
        MODE_LSL = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    localparam logic [SHW-1:0] AMT_MAX = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] AMT_ONE = SHW'(1);
    localparam logic [SHW-1:0] AMT_ZERO = '0;

    state_t           state;
    state_t           state_nxt;
    mode_t            mode_q;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   amt_sat;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;
    logic             accept;
    logic             last_step;

    // Clamp the requested amount so a shift never exceeds WIDTH-1 positions.
    always_comb begin
        amt_sat = amt;
        if (amt > AMT_MAX) begin
            amt_sat = AMT_MAX;
        end
    end

    // One 1-bit step of the working register; step_bit is the bit leaving
    // (or wrapping) on this step and acts as the carry shadow.
    always_comb begin
        step_val = work;
        step_bit = 1'b0;
        case (mode_q)
            MODE_LSR: begin
                step_val = {1'b0, work[WIDTH-1:1]};
                step_bit = work[0];
            end
            MODE_ASR: begin
                step_val = {work[WIDTH-1], work[WIDTH-1:1]};
                step_bit = work[0];
            end
            MODE_LSL: begin
                step_val = {work[WIDTH-2:0], 1'b0};
                step_bit = work[WIDTH-1];
            end
            MODE_ROR: begin
                step_val = {work[0], work[WIDTH-1:1]};
                step_bit = work[0];
            end
            default: begin
                step_val = work;
                step_bit = 1'b0;
            end
        endcase
    end

    assign accept    = (state == ST_IDLE) && start;
    assign last_step = (state == ST_SHIFT) && (cnt == AMT_ONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (amt_sat == AMT_ZERO) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt == AMT_ONE) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Working register, mode and step counter: loaded on accept, stepped in SHIFT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work   <= '0;
            mode_q <= MODE_LSR;
            cnt    <= '0;
        end else if (accept) begin
            work   <= din;
            mode_q <= mode_t'(mode);
            cnt    <= amt_sat;
        end else if (state == ST_SHIFT) begin
            work <= step_val;
            cnt  <= cnt - AMT_ONE;
        end
    end

    // Result registers change only on the edge that enters DONE, so they
    // never expose intermediate shift values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            carry <= 1'b0;
        end else if (accept && (amt_sat == AMT_ZERO)) begin
            dout  <= din;
            carry <= 1'b0;
        end else if (last_step) begin
            dout  <= step_val;
            carry <= step_bit;
        end
    end

endmodule
